// File: rtl/pic_pkg.sv
//------------------------------------------------------------------------------
// Module : pic_pkg
// Brief  : Shared FSM states, command field positions and read-select codes.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pic_pkg;

    typedef enum logic [2:0] {
        S_ICW1  = 3'd0,
        S_ICW2  = 3'd1,
        S_ICW3  = 3'd2,
        S_ICW4  = 3'd3,
        S_READY = 3'd4
    } pic_state_t;

    // Bit positions within the low command byte
    localparam int BIT_IC4       = 0;
    localparam int BIT_SNGL      = 1;
    localparam int BIT_RIS       = 0;
    localparam int BIT_RR        = 1;
    localparam int BIT_POLL      = 2;
    localparam int BIT_ICW1_SEL  = 4;
    localparam int BIT_SMM       = 5;
    localparam int BIT_ESMM      = 6;
    localparam int BIT_OCW3_RSVD = 7;

    localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
    localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

    localparam logic RR_IRR = 1'b0;
    localparam logic RR_ISR = 1'b1;

    function automatic pic_state_t after_icw2(input logic [7:0] icw1_word);
        if (!icw1_word[BIT_SNGL])
            return S_ICW3;
        else if (icw1_word[BIT_IC4])
            return S_ICW4;
        else
            return S_READY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pic_cmd_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : pic_cmd_if
// Brief  : CPU-side command/status bus of the PIC (strobes, address, data).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pic_cmd_if #(
    parameter int DATA_W = 8
);
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              a0;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_oe;

    modport master (
        output cs_n, rd_n, wr_n, a0, din,
        input  dout, dout_oe
    );

    modport slave (
        input  cs_n, rd_n, wr_n, a0, din,
        output dout, dout_oe
    );
endinterface

`default_nettype wire

// File: rtl/pic_strobe_edge.sv
//------------------------------------------------------------------------------
// Module : pic_strobe_edge
// Brief  : Registers a strobe and flags its rising and falling edges.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pic_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic act,
    output logic act_q,
    output logic rise,
    output logic fall
);
    logic r_act;
    logic r_act_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act   <= 1'b0;
            r_act_d <= 1'b0;
        end else begin
            r_act   <= act;
            r_act_d <= r_act;
        end
    end

    assign act_q = r_act;
    assign rise  = r_act & ~r_act_d;
    assign fall  = ~r_act & r_act_d;
endmodule

`default_nettype wire

// File: rtl/pic_cmd_ctrl.sv
//------------------------------------------------------------------------------
// Module : pic_cmd_ctrl
// Brief  : PIC command/status front end: ICW init FSM, OCW decode, IMR, read mux.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pic_cmd_ctrl
    import pic_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] IMR_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    pic_cmd_if.slave          bus,
    input  logic [DATA_W-1:0] irr,
    input  logic [DATA_W-1:0] isr,
    input  logic [7:0]        poll_word,
    output logic              init_done,
    output logic [7:0]        icw1,
    output logic [7:0]        icw3,
    output logic [7:0]        icw4,
    output logic [4:0]        vec_base,
    output logic [DATA_W-1:0] imr,
    output logic              smm,
    output logic              ocw2_vld,
    output logic [7:0]        ocw2_data,
    output logic              poll_req
);
    logic              w_wr_act, w_rd_act;
    logic              w_wr_q, w_wr_rise, w_wr_fall;
    logic              w_rd_q, w_rd_rise, w_rd_fall;
    logic              w_unused;

    logic [DATA_W-1:0] r_wd;
    logic              r_wa0;
    logic              r_ra0;
    logic [7:0]        w_cmd;
    logic              w_commit, w_icw1_hit;

    pic_state_t        r_state, w_state_nxt;
    logic              w_init_done, w_ld_vec, w_ld_icw3, w_ld_icw4, w_ld_imr;
    logic              w_ocw2, w_ocw3;

    logic [7:0]        r_icw1, r_icw3, r_icw4, r_ocw2_data;
    logic [4:0]        r_vec_base;
    logic [DATA_W-1:0] r_imr;
    logic              r_smm, r_rr_sel, r_poll_pend, r_ocw2_vld, r_poll_req;
    logic [DATA_W-1:0] r_dout, w_rd_mux;
    logic              r_dout_oe;

    // A write strobe masks any coincident read so the read never drives the bus
    assign w_wr_act = ~bus.cs_n & ~bus.wr_n;
    assign w_rd_act = ~bus.cs_n & ~bus.rd_n & ~w_wr_act;

    pic_strobe_edge u_wr_edge (
        .clk   (clk),
        .rst   (rst),
        .act   (w_wr_act),
        .act_q (w_wr_q),
        .rise  (w_wr_rise),
        .fall  (w_wr_fall)
    );

    pic_strobe_edge u_rd_edge (
        .clk   (clk),
        .rst   (rst),
        .act   (w_rd_act),
        .act_q (w_rd_q),
        .rise  (w_rd_rise),
        .fall  (w_rd_fall)
    );

    assign w_unused = ^{w_wr_q, w_wr_rise, w_rd_fall};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd  <= '0;
            r_wa0 <= 1'b0;
            r_ra0 <= 1'b0;
        end else begin
            if (w_wr_act) begin
                r_wd  <= bus.din;
                r_wa0 <= bus.a0;
            end
            if (w_rd_act)
                r_ra0 <= bus.a0;
        end
    end

    assign w_cmd      = r_wd[7:0];
    assign w_commit   = w_wr_fall;
    assign w_icw1_hit = w_commit & ~r_wa0 & w_cmd[BIT_ICW1_SEL];

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_ICW1;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_icw1_hit) begin
            w_state_nxt = S_ICW2;
        end else if (w_commit && r_wa0) begin
            case (r_state)
                S_ICW2:  w_state_nxt = after_icw2(r_icw1);
                S_ICW3:  w_state_nxt = r_icw1[BIT_IC4] ? S_ICW4 : S_READY;
                S_ICW4:  w_state_nxt = S_READY;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_init_done = (r_state == S_READY);
        w_ld_vec    = w_commit & r_wa0 & (r_state == S_ICW2);
        w_ld_icw3   = w_commit & r_wa0 & (r_state == S_ICW3);
        w_ld_icw4   = w_commit & r_wa0 & (r_state == S_ICW4);
        w_ld_imr    = w_commit & r_wa0 & w_init_done;
        w_ocw2      = w_commit & ~r_wa0 & w_init_done & (w_cmd[4:3] == OCW_SEL_OCW2);
        w_ocw3      = w_commit & ~r_wa0 & w_init_done & (w_cmd[4:3] == OCW_SEL_OCW3)
                      & ~w_cmd[BIT_OCW3_RSVD];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_icw1      <= '0;
            r_icw3      <= '0;
            r_icw4      <= '0;
            r_vec_base  <= '0;
            r_imr       <= IMR_RST;
            r_smm       <= 1'b0;
            r_rr_sel    <= RR_IRR;
            r_poll_pend <= 1'b0;
            r_ocw2_vld  <= 1'b0;
            r_ocw2_data <= '0;
            r_poll_req  <= 1'b0;
        end else begin
            r_ocw2_vld <= w_ocw2;
            r_poll_req <= w_ocw3 & w_cmd[BIT_POLL];
            if (w_rd_rise)
                r_poll_pend <= 1'b0;
            if (w_icw1_hit) begin
                r_icw1      <= w_cmd;
                r_imr       <= IMR_RST;
                r_rr_sel    <= RR_IRR;
                r_smm       <= 1'b0;
                r_poll_pend <= 1'b0;
            end
            if (w_ld_vec)
                r_vec_base <= w_cmd[7:3];
            if (w_ld_icw3)
                r_icw3 <= w_cmd;
            if (w_ld_icw4)
                r_icw4 <= w_cmd;
            if (w_ld_imr)
                r_imr <= r_wd;
            if (w_ocw2)
                r_ocw2_data <= w_cmd;
            if (w_ocw3) begin
                if (w_cmd[BIT_RR])
                    r_rr_sel <= w_cmd[BIT_RIS];
                if (w_cmd[BIT_ESMM])
                    r_smm <= w_cmd[BIT_SMM];
                if (w_cmd[BIT_POLL])
                    r_poll_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        if (r_poll_pend)
            w_rd_mux = DATA_W'(poll_word);
        else if (r_ra0)
            w_rd_mux = r_imr;
        else if (r_rr_sel == RR_ISR)
            w_rd_mux = isr;
        else
            w_rd_mux = irr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout    <= '0;
            r_dout_oe <= 1'b0;
        end else if (w_rd_rise) begin
            r_dout    <= w_rd_mux;
            r_dout_oe <= 1'b1;
        end else begin
            r_dout_oe <= r_dout_oe & w_rd_q;
        end
    end

    assign bus.dout    = r_dout;
    assign bus.dout_oe = r_dout_oe;
    assign init_done   = w_init_done;
    assign icw1        = r_icw1;
    assign icw3        = r_icw3;
    assign icw4        = r_icw4;
    assign vec_base    = r_vec_base;
    assign imr         = r_imr;
    assign smm         = r_smm;
    assign ocw2_vld    = r_ocw2_vld;
    assign ocw2_data   = r_ocw2_data;
    assign poll_req    = r_poll_req;
endmodule

`default_nettype wire

// File: tb/tb_pic_cmd_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_pic_cmd_ctrl
// Brief  : Directed, table-driven bench for pic_cmd_ctrl.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pic_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irr, isr, poll_word;
    logic       init_done, smm, ocw2_vld, poll_req;
    logic [7:0] icw1, icw3, icw4, imr, ocw2_data;
    logic [4:0] vec_base;

    int checks = 0;
    int errors = 0;

    pic_cmd_if #(.DATA_W(8)) bus ();

    pic_cmd_ctrl #(.DATA_W(8), .IMR_RST(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .irr       (irr),
        .isr       (isr),
        .poll_word (poll_word),
        .init_done (init_done),
        .icw1      (icw1),
        .icw3      (icw3),
        .icw4      (icw4),
        .vec_base  (vec_base),
        .imr       (imr),
        .smm       (smm),
        .ocw2_vld  (ocw2_vld),
        .ocw2_data (ocw2_data),
        .poll_req  (poll_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rd;
        logic       a0;
        logic [7:0] d;
        logic       exp_init;
        logic [7:0] exp_imr;
        logic       exp_smm;
        logic [7:0] exp_dout;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns on the negedge where a committed write is first visible
    task automatic cpu_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = a; bus.din = d;
        @(negedge clk);
        bus.cs_n = 1'b1; bus.wr_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic a, output logic [7:0] data, output logic oe);
        @(negedge clk);
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = a;
        @(negedge clk);
        @(negedge clk);
        data = bus.dout;
        oe   = bus.dout_oe;
        bus.cs_n = 1'b1; bus.rd_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] rdata;
    logic       roe;
    logic       oe_seen;

    initial begin
        //         rd    a0    d      init  imr    smm   dout
        vecs[0]  = '{1'b0, 1'b0, 8'h13, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 8'hAA, 1'b1, 8'hAA, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 8'h00, 1'b1, 8'hAA, 1'b0, 8'hAA};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 8'h81};
        vecs[6]  = '{1'b0, 1'b0, 8'h0B, 1'b1, 8'hAA, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 8'h04};
        vecs[8]  = '{1'b0, 1'b0, 8'h0A, 1'b1, 8'hAA, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 8'h81};
        vecs[10] = '{1'b0, 1'b0, 8'h0C, 1'b1, 8'hAA, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 8'h67};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 8'h81};
        vecs[13] = '{1'b0, 1'b0, 8'h8B, 1'b1, 8'hAA, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 8'h81};
        vecs[15] = '{1'b0, 1'b0, 8'h68, 1'b1, 8'hAA, 1'b1, 8'h00};

        rst = 1'b1;
        bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.a0 = 1'b0; bus.din = 8'h00;
        irr = 8'h81; isr = 8'h04; poll_word = 8'h67;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_init_done", 16'(init_done), 16'h0);
        chk("rst_imr", 16'(imr), 16'h00);
        chk("rst_dout_oe", 16'(bus.dout_oe), 16'h0);
        chk("rst_dout", 16'(bus.dout), 16'h00);
        chk("rst_icw1", 16'(icw1), 16'h00);
        chk("rst_ocw2_vld", 16'(ocw2_vld), 16'h0);

        // T1 plus OCW1/OCW3 read-back table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rd) begin
                cpu_read(vecs[i].a0, rdata, roe);
                chk($sformatf("v%0d_dout", i), 16'(rdata), 16'(vecs[i].exp_dout));
                chk($sformatf("v%0d_oe", i), 16'(roe), 16'h1);
            end else begin
                cpu_write(vecs[i].a0, vecs[i].d);
            end
            chk($sformatf("v%0d_init", i), 16'(init_done), 16'(vecs[i].exp_init));
            chk($sformatf("v%0d_imr", i), 16'(imr), 16'(vecs[i].exp_imr));
            chk($sformatf("v%0d_smm", i), 16'(smm), 16'(vecs[i].exp_smm));
        end
        chk("t1_icw1", 16'(icw1), 16'h13);
        chk("t1_vec_base", 16'(vec_base), 16'h09);
        chk("t1_icw4", 16'(icw4), 16'h01);
        chk("t1_icw3_skipped", 16'(icw3), 16'h00);
        chk("idle_dout_oe", 16'(bus.dout_oe), 16'h0);

        // T3: OCW2 pulse
        cpu_write(1'b0, 8'h20);
        chk("t3_vld_hi", 16'(ocw2_vld), 16'h1);
        chk("t3_data", 16'(ocw2_data), 16'h20);
        chk("t3_imr", 16'(imr), 16'hAA);
        @(negedge clk);
        chk("t3_vld_lo", 16'(ocw2_vld), 16'h0);

        // Poll command pulse and one-shot poll read
        cpu_write(1'b0, 8'h0C);
        chk("poll_req_hi", 16'(poll_req), 16'h1);
        @(negedge clk);
        chk("poll_req_lo", 16'(poll_req), 16'h0);
        cpu_read(1'b0, rdata, roe);
        chk("poll_rd", 16'(rdata), 16'h67);

        // T5: re-init from READY, then reset mid-sequence
        cpu_write(1'b1, 8'hFF);
        chk("t5_imr_ff", 16'(imr), 16'hFF);
        cpu_write(1'b0, 8'h13);
        chk("t5_init_done", 16'(init_done), 16'h0);
        chk("t5_imr_rst", 16'(imr), 16'h00);
        chk("t5_smm_clr", 16'(smm), 16'h0);
        cpu_write(1'b0, 8'h10);
        cpu_write(1'b1, 8'h20);
        chk("t5_vec_mid", 16'(vec_base), 16'h04);
        chk("t5_not_ready", 16'(init_done), 16'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_icw1", 16'(icw1), 16'h00);
        chk("t5_rst_vec", 16'(vec_base), 16'h00);
        chk("t5_rst_icw4", 16'(icw4), 16'h00);
        chk("t5_rst_init", 16'(init_done), 16'h0);
        cpu_write(1'b1, 8'h04);
        chk("t5_icw1_ignores", 16'(icw3), 16'h00);

        // T2: ICW1 without SNGL/IC4 goes through ICW3 only
        cpu_write(1'b0, 8'h10);
        cpu_write(1'b1, 8'h20);
        chk("t2_after_icw2", 16'(init_done), 16'h0);
        cpu_write(1'b1, 8'h04);
        chk("t2_init_done", 16'(init_done), 16'h1);
        chk("t2_icw3", 16'(icw3), 16'h04);
        chk("t2_icw4", 16'(icw4), 16'h00);
        chk("t2_vec_base", 16'(vec_base), 16'h04);
        cpu_write(1'b1, 8'hAA);
        chk("t2_imr", 16'(imr), 16'hAA);

        // T6: simultaneous read and write; write wins
        oe_seen = 1'b0;
        @(negedge clk);
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h55;
        repeat (2) begin @(negedge clk); oe_seen |= bus.dout_oe; end
        bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
        repeat (4) begin @(negedge clk); oe_seen |= bus.dout_oe; end
        chk("t6_imr", 16'(imr), 16'h55);
        chk("t6_no_oe", 16'(oe_seen), 16'h0);

        // Strobes without chip select
        bus.wr_n = 1'b0; bus.din = 8'h33; bus.a0 = 1'b1;
        repeat (2) @(negedge clk);
        bus.wr_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_cs_wr", 16'(imr), 16'h55);
        bus.rd_n = 1'b0;
        repeat (3) begin @(negedge clk); oe_seen |= bus.dout_oe; end
        bus.rd_n = 1'b1;
        chk("t6_cs_rd", 16'(oe_seen), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
